// File: rtl/multi_fifo_rv_if.sv
// Lane-parallel push/pop bundle for multi_fifo_rv: M producer lanes in, N consumer lanes out.
// A lane transfers when valid & ready are both high at posedge. Valid and ready vectors are thermometer
// (lane 0 first). Ready may depend on the other side's ready, but never on valid.
interface multi_fifo_rv_if #(
    parameter int DW = 32,
    parameter int M  = 4,
    parameter int N  = 4
);
    logic [M-1:0]    push_valid;
    logic [M*DW-1:0] push_data;
    logic [M-1:0]    push_ready;
    logic [N-1:0]    pop_valid;
    logic [N*DW-1:0] pop_data;
    logic [N-1:0]    pop_ready;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/multi_fifo_rv.sv
// Multi-lane synchronous FIFO with non-power-of-2 depth. Each cycle it accepts up to M pushes and
// up to N pops. It provides watermarks, a high-water mark, flush and sticky protocol-error flags.
module multi_fifo_rv #(
    parameter int DW     = 32,
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int DEPTH  = 12,
    parameter int AF_LVL = 10,
    parameter int AE_LVL = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    multi_fifo_rv_if.slave               bus,
    input  logic                         flush,
    input  logic                         hwm_clr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   hwm,
    output logic                         err_ovf,
    output logic                         err_unf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = CW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr, wptr_next, rptr_next;
    logic [PW-1:0] waddr [M];
    logic [CW-1:0] npush, npop, count_next, hwm_next;
    logic [AW-1:0] space;
    logic          ovf_now, unf_now;

    assign almost_full  = (int'(count) >= AF_LVL);
    assign almost_empty = (int'(count) <= AE_LVL);

    // Read side depends only on registered state.
    always_comb begin
        logic [AW-1:0] idx;
        bus.pop_valid = '0;
        bus.pop_data  = '0;
        for (int i = 0; i < N; i++) begin
            idx = AW'(rptr) + AW'(i);
            if (idx >= AW'(DEPTH)) idx = idx - AW'(DEPTH);
            bus.pop_valid[i]           = (int'(count) > i);
            bus.pop_data[i*DW +: DW]   = mem[idx[PW-1:0]];
        end
    end

    // Pops are counted over the leading run of lanes only; a gap ends the run.
    always_comb begin
        logic run;
        npop = '0;
        run  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (run && bus.pop_ready[i] && bus.pop_valid[i]) npop = npop + CW'(1);
            else                                             run  = 1'b0;
        end
        unf_now = ((bus.pop_ready & (bus.pop_ready + N'(1))) != '0) ||
                  ((bus.pop_ready & ~bus.pop_valid) != '0);
    end

    // Entries freed by this cycle's pops are lent to the pushes. This makes push_ready depend on
    // pop_ready. It is safe because pop_ready never depends on push_ready.
    always_comb begin
        logic run;
        space          = AW'(DEPTH) - AW'(count) + AW'(npop);
        bus.push_ready = '0;
        npush          = '0;
        run            = 1'b1;
        for (int i = 0; i < M; i++) begin
            bus.push_ready[i] = (space > AW'(i));
            if (run && bus.push_valid[i] && bus.push_ready[i]) npush = npush + CW'(1);
            else                                               run   = 1'b0;
        end
        ovf_now = ((bus.push_valid & (bus.push_valid + M'(1))) != '0);
    end

    always_comb begin
        logic [AW-1:0] wsum, rsum, lane;
        wsum = AW'(wptr) + AW'(npush);
        if (wsum >= AW'(DEPTH)) wsum = wsum - AW'(DEPTH);
        rsum = AW'(rptr) + AW'(npop);
        if (rsum >= AW'(DEPTH)) rsum = rsum - AW'(DEPTH);
        wptr_next = wsum[PW-1:0];
        rptr_next = rsum[PW-1:0];
        for (int i = 0; i < M; i++) begin
            lane = AW'(wptr) + AW'(i);
            if (lane >= AW'(DEPTH)) lane = lane - AW'(DEPTH);
            waddr[i] = lane[PW-1:0];
        end
        count_next = count + npush - npop;
        if (hwm_clr)                 hwm_next = count_next;
        else if (count_next > hwm)   hwm_next = count_next;
        else                         hwm_next = hwm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            hwm     <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            // Violations are recorded even on a flush cycle; hwm is left alone by flush.
            err_ovf <= err_ovf | ovf_now;
            err_unf <= err_unf | unf_now;
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                wptr  <= wptr_next;
                rptr  <= rptr_next;
                count <= count_next;
                hwm   <= hwm_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < M; i++) begin
                if (CW'(i) < npush) mem[waddr[i]] <= bus.push_data[i*DW +: DW];
            end
        end
    end
endmodule

// File: tb/tb_multi_fifo_rv.sv
// Directed bench for multi_fifo_rv: a queue-based reference model is checked on every cycle, and
// literal expectations are checked at the key points of each scenario.
module tb_multi_fifo_rv;
    localparam int DW = 32, M = 4, N = 4, DEPTH = 12, AF_LVL = 10, AE_LVL = 2;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, hwm_clr;
    logic [CW-1:0] count, hwm;
    logic          almost_full, almost_empty, err_ovf, err_unf;

    multi_fifo_rv_if #(.DW(DW), .M(M), .N(N)) bus ();

    multi_fifo_rv #(.DW(DW), .M(M), .N(N), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .flush        (flush),
        .hwm_clr      (hwm_clr),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .hwm          (hwm),
        .err_ovf      (err_ovf),
        .err_unf      (err_unf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    int            m_hwm;
    logic          m_ovf, m_unf;
    bit            model_ok = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lead_pop(input int sz);
        int n = 0;
        for (int i = 0; i < N; i++) begin
            if (bus.pop_ready[i] && i < sz) n++;
            else break;
        end
        return n;
    endfunction

    function automatic int lead_push();
        int n = 0;
        for (int i = 0; i < M; i++) begin
            if (bus.push_valid[i]) n++;
            else break;
        end
        return n;
    endfunction

    // Reference model: pop the consumed lanes first, then fill the remaining room in lane order.
    task automatic model_step();
        int  sz, np, nw;
        bit  gap, bad;
        if (rst) begin
            exp_q.delete();
            m_hwm    = 0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            model_ok = 1'b1;
            return;
        end
        if (!model_ok) return;
        sz  = exp_q.size();
        gap = 1'b0; bad = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (!bus.push_valid[i]) gap = 1'b1;
            else if (gap)           bad = 1'b1;
        end
        if (bad) m_ovf = 1'b1;
        gap = 1'b0; bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!bus.pop_ready[i])   gap = 1'b1;
            else if (gap || i >= sz) bad = 1'b1;
        end
        if (bad) m_unf = 1'b1;
        if (flush) begin
            exp_q.delete();
            return;
        end
        np = lead_pop(sz);
        for (int k = 0; k < np; k++) void'(exp_q.pop_front());
        nw = lead_push();
        if (nw > DEPTH - exp_q.size()) nw = DEPTH - exp_q.size();
        for (int k = 0; k < nw; k++) exp_q.push_back(bus.push_data[k*DW +: DW]);
        if (hwm_clr)                  m_hwm = exp_q.size();
        else if (exp_q.size() > m_hwm) m_hwm = exp_q.size();
    endtask

    task automatic compare();
        int           sz = exp_q.size();
        int           np = lead_pop(sz);
        logic [M-1:0] exp_pr;
        logic [N-1:0] exp_pv;
        for (int i = 0; i < M; i++) exp_pr[i] = ((DEPTH - sz + np) > i);
        for (int i = 0; i < N; i++) exp_pv[i] = (i < sz);
        chk("count", count, sz);
        chk("pop_valid", bus.pop_valid, exp_pv);
        chk("push_ready", bus.push_ready, exp_pr);
        chk("almost_full", almost_full, sz >= AF_LVL);
        chk("almost_empty", almost_empty, sz <= AE_LVL);
        chk("hwm", hwm, m_hwm);
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_unf", err_unf, m_unf);
        for (int i = 0; i < N; i++)
            if (i < sz) chk("pop_data", bus.pop_data[i*DW +: DW], exp_q[i]);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) compare();
    end

    function automatic logic [M*DW-1:0] pk(input logic [DW-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic drive(input logic [M-1:0] pv, input logic [M*DW-1:0] pd, input logic [N-1:0] pr,
                         input logic fl, input logic clr);
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_ready  = pr;
        flush          = fl;
        hwm_clr        = clr;
    endtask

    task automatic idle();
        drive('0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_pop_valid", bus.pop_valid, 4'b0000);
        chk("rst_push_ready", bus.push_ready, 4'b1111);
        chk("rst_err", {err_ovf, err_unf}, 2'b00);
        chk("rst_hwm", hwm, 0);

        // Fill with A0..A11, then drain three per cycle across the pointer wrap
        for (int k = 0; k < 3; k++) begin
            step();
            drive(4'b1111, pk(32'hA000_0000 + 4*k, 32'hA000_0001 + 4*k,
                              32'hA000_0002 + 4*k, 32'hA000_0003 + 4*k), '0, 1'b0, 1'b0);
        end
        step();
        idle();
        @(negedge clk);
        chk("fill_count", count, 12);
        chk("fill_push_ready", bus.push_ready, 4'b0000);
        chk("fill_almost_full", almost_full, 1'b1);
        for (int j = 0; j < 4; j++) begin
            step();
            drive('0, '0, 4'b0111, 1'b0, 1'b0);
            @(negedge clk);
            for (int l = 0; l < 3; l++)
                chk("drain_order", bus.pop_data[l*DW +: DW], 32'hA000_0000 + 3*j + l);
        end
        step();
        idle();
        @(negedge clk);
        chk("drain_count", count, 0);

        // Push and pop together while full
        for (int k = 0; k < 3; k++) begin
            step();
            drive(4'b1111, pk(32'hB000_0000 + 4*k, 32'hB000_0001 + 4*k,
                              32'hB000_0002 + 4*k, 32'hB000_0003 + 4*k), '0, 1'b0, 1'b0);
        end
        step();
        drive(4'b0011, pk(32'hC000_0000, 32'hC000_0001, 32'h0, 32'h0), 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_pp_push_ready", bus.push_ready, 4'b0011);
        chk("full_pp_lane0", bus.pop_data[0 +: DW], 32'hB000_0000);
        step();
        idle();
        @(negedge clk);
        chk("full_pp_count", count, 12);
        chk("full_pp_head", bus.pop_data[0 +: DW], 32'hB000_0002);

        // Partial accept at count 10
        step();
        drive('0, '0, 4'b0011, 1'b0, 1'b0);
        step();
        drive(4'b1111, pk(32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003),
              '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("part_count10", count, 10);
        chk("part_almost_full", almost_full, 1'b1);
        chk("part_push_ready", bus.push_ready, 4'b0011);
        step();
        idle();
        @(negedge clk);
        chk("part_count12", count, 12);
        for (int j = 0; j < 3; j++) begin
            step();
            drive('0, '0, 4'b1111, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("part_tail_d0", bus.pop_data[2*DW +: DW], 32'hD000_0000);
        chk("part_tail_d1", bus.pop_data[3*DW +: DW], 32'hD000_0001);
        step();
        idle();
        @(negedge clk);
        chk("part_empty", count, 0);
        chk("part_almost_empty", almost_empty, 1'b1);

        // Protocol errors
        step();
        drive(4'b0101, pk(32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003),
              '0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("ovf_flag", err_ovf, 1'b1);
        chk("ovf_count", count, 1);
        chk("ovf_lane0", bus.pop_data[0 +: DW], 32'hE000_0000);
        chk("ovf_unf_clear", err_unf, 1'b0);
        step();
        drive('0, '0, 4'b0001, 1'b0, 1'b0);
        step();
        drive('0, '0, 4'b0001, 1'b0, 1'b0);
        step();
        idle();
        repeat (3) step();
        @(negedge clk);
        chk("unf_flag", err_unf, 1'b1);
        chk("ovf_sticky", err_ovf, 1'b1);
        chk("unf_count", count, 0);

        // Flush keeps hwm; hwm_clr reloads it
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_err", {err_ovf, err_unf}, 2'b00);
        step();
        drive(4'b1111, pk(32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003),
              '0, 1'b0, 1'b0);
        step();
        drive(4'b0111, pk(32'hF000_0004, 32'hF000_0005, 32'hF000_0006, 32'h0), '0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("pre_flush_count", count, 7);
        chk("pre_flush_hwm", hwm, 7);
        chk("pre_flush_ae", almost_empty, 1'b0);
        step();
        drive(4'b1111, pk(32'h1, 32'h2, 32'h3, 32'h4), 4'b0011, 1'b1, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("flush_count", count, 0);
        chk("flush_hwm", hwm, 7);
        chk("flush_pop_valid", bus.pop_valid, 4'b0000);
        step();
        drive('0, '0, '0, 1'b0, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk("hwm_clr", hwm, 0);
        step();
        drive(4'b0011, pk(32'h6000_0000, 32'h6000_0001, 32'h0, 32'h0), '0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("post_flush_head", bus.pop_data[0 +: DW], 32'h6000_0000);
        chk("post_flush_hwm", hwm, 2);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
